// File: rtl/tt_pin_pattern_gen.sv
// Switchable digital stimulus for an analog tile: drives a pattern bus and its
// output enable from a runtime-selected mode, stepping at a prescaled rate.
//
// state  | meaning
// IDLE   | outputs tied off (0), waiting for ena or a config
// RELOAD | one cycle after a config accept; reseed, outputs held at 0
// RUN    | pattern active, steps every div_r+1 cycles
module tt_pin_pattern_gen #(
  parameter int         WIDTH        = 8,
  parameter int         PRESC_W      = 16,
  parameter logic [2:0] DEFAULT_MODE = 3'd0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [2:0]         cfg_mode,
  input  logic [PRESC_W-1:0] cfg_div,
  input  logic [WIDTH-1:0]   cfg_oe,
  input  logic [WIDTH-1:0]   din,
  output logic [WIDTH-1:0]   pat_out,
  output logic [WIDTH-1:0]   pat_oe,
  output logic               tick
);

  localparam logic [2:0] MODE_HIGH   = 3'd1;
  localparam logic [2:0] MODE_COUNT  = 3'd2;
  localparam logic [2:0] MODE_WALK1  = 3'd3;
  localparam logic [2:0] MODE_MIRROR = 3'd4;
  localparam logic [2:0] MODE_TOGGLE = 3'd5;

  typedef enum logic [1:0] {IDLE, RELOAD, RUN} state_t;

  state_t             state, state_nxt;
  logic [2:0]         mode_r;
  logic [PRESC_W-1:0] div_r;
  logic [WIDTH-1:0]   oe_r;
  logic [PRESC_W-1:0] presc;
  logic [WIDTH-1:0]   pattern;
  logic [WIDTH-1:0]   seed_val;
  logic [WIDTH-1:0]   next_val;
  logic               accept;

  function automatic logic [WIDTH-1:0] seed_of(input logic [2:0] m,
                                               input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] alt;
    alt = '0;
    for (int i = 0; i < WIDTH; i++) alt[i] = ((i % 2) == 0);
    case (m)
      MODE_HIGH:   seed_of = '1;
      MODE_WALK1:  seed_of = WIDTH'(1);
      MODE_MIRROR: seed_of = d;
      MODE_TOGGLE: seed_of = alt;
      default:     seed_of = '0;
    endcase
  endfunction

  // Reserved modes 6/7 fall into the default arm and behave as tie-low.
  function automatic logic [WIDTH-1:0] next_of(input logic [2:0] m,
                                               input logic [WIDTH-1:0] p,
                                               input logic [WIDTH-1:0] d);
    case (m)
      MODE_HIGH:   next_of = '1;
      MODE_COUNT:  next_of = p + WIDTH'(1);
      MODE_WALK1:  next_of = (p << 1) | (p >> (WIDTH - 1));
      MODE_MIRROR: next_of = d;
      MODE_TOGGLE: next_of = ~p;
      default:     next_of = '0;
    endcase
  endfunction

  assign cfg_ready = (state != RELOAD);
  assign accept    = cfg_valid && cfg_ready;

  always_comb begin
    seed_val = seed_of(mode_r, din);
    next_val = next_of(mode_r, pattern, din);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RELOAD;
               else if (ena) state_nxt = RUN;
      RELOAD:  state_nxt = ena ? RUN : IDLE;
      RUN:     if (accept) state_nxt = RELOAD;
               else if (!ena) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r  <= DEFAULT_MODE;
      div_r   <= '0;
      oe_r    <= '0;
      presc   <= '0;
      pattern <= '0;
      pat_out <= '0;
      pat_oe  <= '0;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (accept) begin
        mode_r  <= cfg_mode;
        div_r   <= cfg_div;
        oe_r    <= cfg_oe;
        pat_out <= '0;
        pat_oe  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (ena) begin
              presc   <= '0;
              pattern <= seed_val;
              pat_out <= seed_val;
              pat_oe  <= oe_r;
            end
          end
          RELOAD: begin
            presc   <= '0;
            pattern <= seed_val;
            if (ena) begin
              pat_out <= seed_val;
              pat_oe  <= oe_r;
            end
          end
          RUN: begin
            if (!ena) begin
              pat_out <= '0;
              pat_oe  <= '0;
            end else if (presc == div_r) begin
              presc   <= '0;
              pattern <= next_val;
              pat_out <= next_val;
              tick    <= 1'b1;
            end else begin
              presc <= presc + PRESC_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tt_pin_pattern_gen.sv
// Scoreboard bench for tt_pin_pattern_gen: each scenario queues the expected
// per-cycle outputs, then clocks the DUT and compares against the queue.
module tb_tt_pin_pattern_gen;

  logic        clk, rst, ena, cfg_valid, cfg_ready, tick;
  logic [2:0]  cfg_mode;
  logic [15:0] cfg_div;
  logic [7:0]  cfg_oe, din, pat_out, pat_oe;

  int n_run  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [7:0] out;
    logic [7:0] oe;
    logic       tk;
    logic       rdy;
  } exp_t;

  exp_t sb[$];

  tt_pin_pattern_gen dut (
    .clk(clk), .rst(rst), .ena(ena),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_mode(cfg_mode), .cfg_div(cfg_div), .cfg_oe(cfg_oe),
    .din(din), .pat_out(pat_out), .pat_oe(pat_oe), .tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [7:0] o, input logic [7:0] e,
                              input logic t, input logic r);
    mk = {o, e, t, r};
  endfunction

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [2:0] m, input logic [15:0] d, input logic [7:0] oe);
    cfg_valid = 1'b1;
    cfg_mode  = m;
    cfg_div   = d;
    cfg_oe    = oe;
  endtask

  task automatic test_reset();
    exp_t e;
    #1;
    repeat (2) step_clk();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) sb.push_back(mk(8'h00, 8'h00, 1'b0, 1'b1));
    for (int i = 0; i < 10; i++) begin
      step_clk();
      e = sb.pop_front();
      n_run++;
      if ({pat_out, pat_oe, tick, cfg_ready} !== e) begin
        n_fail++;
        $display("FAIL reset[%0d]: got out=%h oe=%h tick=%b rdy=%b, expected out=%h oe=%h tick=%b rdy=%b",
                 i, pat_out, pat_oe, tick, cfg_ready, e.out, e.oe, e.tk, e.rdy);
      end
    end
  endtask

  task automatic test_count();
    exp_t e;
    logic [7:0] v;
    ena = 1'b1;
    cfg(3'd2, 16'd0, 8'hFF);
    sb.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0));
    sb.push_back(mk(8'h00, 8'hFF, 1'b0, 1'b1));
    v = 8'h00;
    for (int k = 1; k <= 260; k++) begin
      v = v + 8'd1;
      sb.push_back(mk(v, 8'hFF, 1'b1, 1'b1));
    end
    for (int i = 0; i < 262; i++) begin
      step_clk();
      cfg_valid = 1'b0;
      e = sb.pop_front();
      n_run++;
      if ({pat_out, pat_oe, tick, cfg_ready} !== e) begin
        n_fail++;
        $display("FAIL count[%0d]: got out=%h oe=%h tick=%b rdy=%b, expected out=%h oe=%h tick=%b rdy=%b",
                 i, pat_out, pat_oe, tick, cfg_ready, e.out, e.oe, e.tk, e.rdy);
      end
    end
  endtask

  task automatic test_walk1();
    exp_t e;
    logic [7:0] v;
    int n;
    cfg(3'd3, 16'd3, 8'hFF);
    sb.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0));
    v = 8'h01;
    sb.push_back(mk(v, 8'hFF, 1'b0, 1'b1));
    for (int j = 1; j <= 9; j++) begin
      repeat (3) sb.push_back(mk(v, 8'hFF, 1'b0, 1'b1));
      v = {v[6:0], v[7]};
      sb.push_back(mk(v, 8'hFF, 1'b1, 1'b1));
    end
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      step_clk();
      cfg_valid = 1'b0;
      e = sb.pop_front();
      n_run++;
      if ({pat_out, pat_oe, tick, cfg_ready} !== e) begin
        n_fail++;
        $display("FAIL walk1[%0d]: got out=%h oe=%h tick=%b rdy=%b, expected out=%h oe=%h tick=%b rdy=%b",
                 i, pat_out, pat_oe, tick, cfg_ready, e.out, e.oe, e.tk, e.rdy);
      end
    end
  endtask

  task automatic test_mirror();
    exp_t e;
    logic [7:0] cur;
    cur = 8'h00;
    cfg(3'd4, 16'd1, 8'h0F);
    for (int i = 0; i <= 12; i++) begin
      din = 8'(8'h40 + 3 * i);
      if (i == 0) sb.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0));
      else if (i == 1) begin
        cur = din;
        sb.push_back(mk(cur, 8'h0F, 1'b0, 1'b1));
      end else if ((i % 2) == 0) sb.push_back(mk(cur, 8'h0F, 1'b0, 1'b1));
      else begin
        cur = din;
        sb.push_back(mk(cur, 8'h0F, 1'b1, 1'b1));
      end
      step_clk();
      cfg_valid = 1'b0;
      e = sb.pop_front();
      n_run++;
      if ({pat_out, pat_oe, tick, cfg_ready} !== e) begin
        n_fail++;
        $display("FAIL mirror[%0d]: got out=%h oe=%h tick=%b rdy=%b, expected out=%h oe=%h tick=%b rdy=%b",
                 i, pat_out, pat_oe, tick, cfg_ready, e.out, e.oe, e.tk, e.rdy);
      end
    end
  endtask

  task automatic test_toggle_ena();
    exp_t e;
    cfg(3'd5, 16'd2, 8'hFF);
    sb.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0));
    sb.push_back(mk(8'h55, 8'hFF, 1'b0, 1'b1));
    repeat (2) sb.push_back(mk(8'h55, 8'hFF, 1'b0, 1'b1));
    sb.push_back(mk(8'hAA, 8'hFF, 1'b1, 1'b1));
    repeat (2) sb.push_back(mk(8'h00, 8'h00, 1'b0, 1'b1));
    sb.push_back(mk(8'h55, 8'hFF, 1'b0, 1'b1));
    repeat (2) sb.push_back(mk(8'h55, 8'hFF, 1'b0, 1'b1));
    sb.push_back(mk(8'hAA, 8'hFF, 1'b1, 1'b1));
    repeat (2) sb.push_back(mk(8'hAA, 8'hFF, 1'b0, 1'b1));
    sb.push_back(mk(8'h55, 8'hFF, 1'b1, 1'b1));
    for (int c = 0; c < 14; c++) begin
      ena = (c < 5 || c >= 7);
      step_clk();
      cfg_valid = 1'b0;
      e = sb.pop_front();
      n_run++;
      if ({pat_out, pat_oe, tick, cfg_ready} !== e) begin
        n_fail++;
        $display("FAIL toggle_ena[%0d]: got out=%h oe=%h tick=%b rdy=%b, expected out=%h oe=%h tick=%b rdy=%b",
                 c, pat_out, pat_oe, tick, cfg_ready, e.out, e.oe, e.tk, e.rdy);
      end
    end
  endtask

  task automatic test_accept_ena_fall();
    exp_t e;
    cfg(3'd7, 16'd0, 8'hFF);
    sb.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0));
    repeat (2) sb.push_back(mk(8'h00, 8'h00, 1'b0, 1'b1));
    sb.push_back(mk(8'h00, 8'hFF, 1'b0, 1'b1));
    repeat (3) sb.push_back(mk(8'h00, 8'hFF, 1'b1, 1'b1));
    for (int c = 0; c < 7; c++) begin
      ena = (c >= 3);
      step_clk();
      cfg_valid = 1'b0;
      e = sb.pop_front();
      n_run++;
      if ({pat_out, pat_oe, tick, cfg_ready} !== e) begin
        n_fail++;
        $display("FAIL accept_ena_fall[%0d]: got out=%h oe=%h tick=%b rdy=%b, expected out=%h oe=%h tick=%b rdy=%b",
                 c, pat_out, pat_oe, tick, cfg_ready, e.out, e.oe, e.tk, e.rdy);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    cfg(3'd1, 16'd0, 8'hFF);
    sb.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0));
    sb.push_back(mk(8'hFF, 8'hFF, 1'b0, 1'b1));
    repeat (3) sb.push_back(mk(8'hFF, 8'hFF, 1'b1, 1'b1));
    for (int c = 0; c < 5; c++) begin
      step_clk();
      cfg_valid = 1'b0;
      e = sb.pop_front();
      n_run++;
      if ({pat_out, pat_oe, tick, cfg_ready} !== e) begin
        n_fail++;
        $display("FAIL async_pre[%0d]: got out=%h oe=%h tick=%b rdy=%b, expected out=%h oe=%h tick=%b rdy=%b",
                 c, pat_out, pat_oe, tick, cfg_ready, e.out, e.oe, e.tk, e.rdy);
      end
    end
    #2 rst = 1'b1;
    #1;
    n_run++;
    if ({pat_out, pat_oe, tick, cfg_ready} !== mk(8'h00, 8'h00, 1'b0, 1'b1)) begin
      n_fail++;
      $display("FAIL async_assert: got out=%h oe=%h tick=%b rdy=%b, expected out=00 oe=00 tick=0 rdy=1",
               pat_out, pat_oe, tick, cfg_ready);
    end
    ena = 1'b0;
    step_clk();
    rst = 1'b0;
    repeat (2) sb.push_back(mk(8'h00, 8'h00, 1'b0, 1'b1));
    sb.push_back(mk(8'h00, 8'h00, 1'b0, 1'b1));
    repeat (2) sb.push_back(mk(8'h00, 8'h00, 1'b1, 1'b1));
    for (int c = 0; c < 5; c++) begin
      ena = (c >= 2);
      step_clk();
      e = sb.pop_front();
      n_run++;
      if ({pat_out, pat_oe, tick, cfg_ready} !== e) begin
        n_fail++;
        $display("FAIL async_post[%0d]: got out=%h oe=%h tick=%b rdy=%b, expected out=%h oe=%h tick=%b rdy=%b",
                 c, pat_out, pat_oe, tick, cfg_ready, e.out, e.oe, e.tk, e.rdy);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    ena       = 1'b0;
    cfg_valid = 1'b0;
    cfg_mode  = 3'd0;
    cfg_div   = 16'd0;
    cfg_oe    = 8'h00;
    din       = 8'h00;
    test_reset();
    test_count();
    test_walk1();
    test_mirror();
    test_toggle_ena();
    test_accept_ena_fall();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
